// File: rtl/bcd_ctrl_pkg.sv
// Shared types and constants for the BCD converter arbiter.
package bcd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    CAPTURE = 2'd2,
    RESPOND = 2'd3
  } state_e;

  localparam int DATA_W_DEF     = 36;
  localparam int NUM_DIGITS_DEF = 11;
  localparam int BCD_MAX_NIBBLE = 9;

  // Width of a field that must hold values 0..n-1 (never below one bit).
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr.
module rr_arbiter
  import bcd_ctrl_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int ID_W    = idw(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] cand;
  logic            found;

  // Walk the ring from ptr; the first hit wins and later hits are masked.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      cand = sum[ID_W-1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Shares one fixed-latency binary-to-BCD converter among NUM_REQ requesters.
module bcd_convert_arbiter
  import bcd_ctrl_pkg::*;
#(
  parameter int  NUM_REQ      = 4,
  parameter int  DATA_W       = DATA_W_DEF,
  parameter int  NUM_DIGITS   = NUM_DIGITS_DEF,
  parameter int  CONV_LATENCY = 40,
  localparam int ID_W         = idw(NUM_REQ),
  localparam int SD_W         = idw(NUM_DIGITS + 1)
) (
  input  logic                             Clk,
  input  logic                             Reset_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             conv_enable,
  output logic [DATA_W-1:0]                conv_data,
  input  logic [NUM_DIGITS-1:0][3:0]       conv_bcd,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [ID_W-1:0]                  rsp_id,
  output logic [NUM_DIGITS-1:0][3:0]       rsp_bcd,
  output logic [SD_W-1:0]                  rsp_sig_digits,
  output logic                             rsp_error
);

  localparam int CNT_W = idw(CONV_LATENCY + 1);

  state_e                 state, state_n;
  logic [ID_W-1:0]        ptr;
  logic [CNT_W-1:0]       cnt;
  logic [NUM_REQ-1:0]     gnt_oh;
  logic [ID_W-1:0]        gnt_idx;
  logic [NUM_DIGITS-1:0]  nib_bad;
  logic [SD_W-1:0]        sig_d;
  logic                   hs;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt_oh),
    .gnt_idx (gnt_idx)
  );

  // Per-digit range check on the converter output.
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    assign nib_bad[d] = (conv_bcd[d] > 4'(BCD_MAX_NIBBLE));
  end

  // Significant digits: one past the highest nonzero nibble, floor of one.
  always_comb begin
    sig_d = SD_W'(1);
    for (int i = 0; i < NUM_DIGITS; i++)
      if (conv_bcd[i] != 4'd0) sig_d = SD_W'(i + 1);
  end

  assign hs = (state == RESPOND) && rsp_ready;

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Next-state: grant -> fixed-latency wait -> capture -> hold until taken.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (|req_valid) state_n = CONVERT;
      CONVERT: if (cnt == CNT_W'(CONV_LATENCY - 1)) state_n = CAPTURE;
      CAPTURE: state_n = RESPOND;
      RESPOND: if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    rsp_valid = (state == RESPOND);
  end

  // Datapath: grant bookkeeping, latency counter, result capture, pointer.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      req_ready      <= '0;
      conv_enable    <= 1'b0;
      conv_data      <= '0;
      rsp_id         <= '0;
      rsp_bcd        <= '0;
      rsp_sig_digits <= '0;
      rsp_error      <= 1'b0;
      cnt            <= '0;
      ptr            <= '0;
    end else begin
      // Strobes are single-cycle; conv_enable lands in the first CONVERT cycle.
      req_ready   <= '0;
      conv_enable <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req_valid) begin
            req_ready   <= gnt_oh;
            conv_enable <= 1'b1;
            conv_data   <= req_data[gnt_idx];
            rsp_id      <= gnt_idx;
            cnt         <= '0;
          end
        end
        CONVERT: cnt <= cnt + CNT_W'(1);
        CAPTURE: begin
          rsp_bcd        <= conv_bcd;
          rsp_error      <= |nib_bad;
          rsp_sig_digits <= sig_d;
        end
        RESPOND: begin
          // Served requester drops to lowest priority.
          if (hs) ptr <= (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + ID_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
